// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared widths, address-map limits, port ids and grant-state encoding.
package bram_arb_pkg;
    localparam int ADDR_W       = 14;
    localparam int DATA_W       = 8;
    localparam int DEPTH        = 15360;
    localparam int PROT_LIMIT   = 8192;
    localparam int STARVE_LIMIT = 4;
    localparam int STARVE_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;
    typedef enum logic {CPU_PRI, LDR_FORCE} grant_state_e;
    typedef logic [STARVE_W-1:0] starve_t;
    typedef struct packed {
        logic valid;
        logic port;
        logic rd;
        logic oor;
        logic err;
    } resp_t;
endpackage

// File: rtl/bram_arbiter_if.sv
// bram_arbiter_if: request/response lines of the CPU and LDR ports plus the block-RAM side.
interface bram_arbiter_if;
    import bram_arb_pkg::*;
    logic              cpu_valid, cpu_we, cpu_ready, cpu_ack;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              ldr_valid, ldr_we, ldr_ready, ldr_ack;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata, ldr_rdata;
    logic              wp_en, ram_we, err;
    logic [ADDR_W-1:0] ram_addr, ram_addr_w;
    logic [DATA_W-1:0] ram_din, ram_dout;
    modport master (
        output cpu_valid, cpu_we, cpu_addr, cpu_wdata,
        output ldr_valid, ldr_we, ldr_addr, ldr_wdata,
        output wp_en, ram_dout,
        input  cpu_ready, cpu_ack, cpu_rdata, ldr_ready, ldr_ack, ldr_rdata,
        input  ram_we, ram_addr, ram_addr_w, ram_din, err
    );
    modport slave (
        input  cpu_valid, cpu_we, cpu_addr, cpu_wdata,
        input  ldr_valid, ldr_we, ldr_addr, ldr_wdata,
        input  wp_en, ram_dout,
        output cpu_ready, cpu_ack, cpu_rdata, ldr_ready, ldr_ack, ldr_rdata,
        output ram_we, ram_addr, ram_addr_w, ram_din, err
    );
endinterface

// File: rtl/bram_arb_grant.sv
// bram_arb_grant: fixed CPU priority; LDR wins once after STARVE_LIMIT consecutive lost cycles.
module bram_arb_grant
    import bram_arb_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic cpu_valid,
    input  logic ldr_valid,
    output logic grant_cpu,
    output logic grant_ldr
);
    grant_state_e state_q;
    starve_t      starve_q, starve_d;
    always_comb begin
        grant_ldr = reset_n && ldr_valid && (state_q == LDR_FORCE || !cpu_valid);
        grant_cpu = reset_n && cpu_valid && !grant_ldr;
        starve_d  = (grant_ldr || !ldr_valid) ? '0 : grant_cpu ? starve_q + starve_t'(1) : starve_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= CPU_PRI;
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
            state_q  <= (state_q == CPU_PRI)
                      ? ((starve_d == starve_t'(STARVE_LIMIT)) ? LDR_FORCE : CPU_PRI)
                      : ((grant_ldr || !ldr_valid) ? CPU_PRI : LDR_FORCE);
        end
    end
endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: two-port block-RAM arbiter with ROM write protection and out-of-range handling.
// Accesses issue to the RAM in the accept cycle; ack, rdata and err follow one cycle later.
module bram_arbiter
    import bram_arb_pkg::*;
(
    input logic           clk,
    input logic           reset_n,
    bram_arbiter_if.slave bus
);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PROT_A  = ADDR_W'(PROT_LIMIT);
    logic              grant_cpu, grant_ldr, acc, req_we, oor, blocked;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata, rd_data, cpu_rdata_q, ldr_rdata_q;
    resp_t             resp_q, resp_d;
    bram_arb_grant u_grant (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_valid (bus.cpu_valid),
        .ldr_valid (bus.ldr_valid),
        .grant_cpu (grant_cpu),
        .grant_ldr (grant_ldr)
    );
    always_comb begin
        acc            = grant_cpu || grant_ldr;
        req_we         = grant_ldr ? bus.ldr_we    : bus.cpu_we;
        req_addr       = grant_ldr ? bus.ldr_addr  : bus.cpu_addr;
        req_wdata      = grant_ldr ? bus.ldr_wdata : bus.cpu_wdata;
        oor            = req_addr >= DEPTH_A;
        // LDR writes bypass protection so the host can load the ROM image
        blocked        = grant_cpu && bus.wp_en && req_addr < PROT_A;
        bus.cpu_ready  = grant_cpu;
        bus.ldr_ready  = grant_ldr;
        bus.ram_we     = acc && req_we && !oor && !blocked;
        bus.ram_addr   = (acc && !oor) ? req_addr : '0;
        bus.ram_addr_w = bus.ram_addr;
        bus.ram_din    = bus.ram_we ? req_wdata : '0;
        resp_d         = '{valid: acc, port: grant_ldr ? PORT_LDR : PORT_CPU, rd: !req_we,
                           oor: oor, err: oor || (req_we && blocked)};
        rd_data        = resp_q.oor ? '1 : bus.ram_dout;
        bus.cpu_ack    = resp_q.valid && resp_q.port == PORT_CPU;
        bus.ldr_ack    = resp_q.valid && resp_q.port == PORT_LDR;
        bus.cpu_rdata  = (bus.cpu_ack && resp_q.rd) ? rd_data : cpu_rdata_q;
        bus.ldr_rdata  = (bus.ldr_ack && resp_q.rd) ? rd_data : ldr_rdata_q;
        bus.err        = resp_q.valid && resp_q.err;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_q      <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            resp_q      <= resp_d;
            cpu_rdata_q <= bus.cpu_rdata;
            ldr_rdata_q <= bus.ldr_rdata;
        end
    end
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed and random two-port traffic checked by a scoreboard over a flat memory model.
module tb_bram_arbiter;
    import bram_arb_pkg::*;
    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                gap;
    } req_t;
    typedef struct {
        logic              rd;
        logic [DATA_W-1:0] data;
        logic              err;
    } exp_t;
    logic clk = 0;
    logic reset_n = 1;
    bram_arbiter_if bus();
    bram_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
    logic [DATA_W-1:0] ram     [1<<ADDR_W];
    logic [DATA_W-1:0] ref_mem [1<<ADDR_W];
    always @(posedge clk) begin
        if (bus.ram_we) ram[bus.ram_addr_w] <= bus.ram_din;
        bus.ram_dout <= ram[bus.ram_addr];
    end
    int vectors = 0;
    int miscompares = 0;
    req_t req_q[2][$];
    exp_t exp_q[2][$];
    logic [DATA_W-1:0] last[2];
    logic cpu_hs = 0;
    logic ldr_hs = 0;
    int ldr_wait = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic check_port(input int p, input logic ack, input logic [DATA_W-1:0] rdata);
        exp_t e;
        string n;
        n = (p == 0) ? "cpu" : "ldr";
        chk({n, " ack"}, 32'(ack), 32'(exp_q[p].size() != 0));
        if (ack && exp_q[p].size() != 0) begin
            e = exp_q[p].pop_front();
            chk({n, " err"}, 32'(bus.err), 32'(e.err));
            if (e.rd) begin
                chk({n, " rdata"}, 32'(rdata), 32'(e.data));
                last[p] = e.data;
            end
        end else begin
            if (exp_q[p].size() != 0) void'(exp_q[p].pop_front());
            chk({n, " rdata hold"}, 32'(rdata), 32'(last[p]));
        end
    endtask
    task automatic accept(input int p, input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        exp_t e;
        string n;
        logic oor, prot;
        n = (p == 0) ? "cpu" : "ldr";
        oor = int'(addr) >= DEPTH;
        prot = p == 0 && bus.wp_en && int'(addr) < PROT_LIMIT;
        if (we) begin
            chk({n, " ram_we"}, 32'(bus.ram_we), 32'(!oor && !prot));
            if (!oor && !prot) begin
                chk({n, " ram_addr_w"}, 32'(bus.ram_addr_w), 32'(addr));
                chk({n, " ram_din"}, 32'(bus.ram_din), 32'(wdata));
                ref_mem[addr] = wdata;
            end
            e = '{rd: 1'b0, data: '0, err: oor || prot};
        end else begin
            chk({n, " ram_we on read"}, 32'(bus.ram_we), 32'(0));
            chk({n, " ram_addr"}, 32'(bus.ram_addr), oor ? 32'(0) : 32'(addr));
            e = '{rd: 1'b1, data: oor ? 8'hFF : ref_mem[addr], err: oor};
        end
        exp_q[p].push_back(e);
    endtask
    initial forever begin : monitor
        logic exp_c, exp_l;
        @(negedge clk);
        if (!reset_n) begin
            chk("rst ctrl", 32'({bus.cpu_ready, bus.ldr_ready, bus.cpu_ack, bus.ldr_ack, bus.err, bus.ram_we}), 32'(0));
            chk("rst ram addr", 32'({bus.ram_addr, bus.ram_addr_w}), 32'(0));
            chk("rst data", 32'({bus.ram_din, bus.cpu_rdata, bus.ldr_rdata}), 32'(0));
            exp_q[0].delete();
            exp_q[1].delete();
            last[0] = '0;
            last[1] = '0;
            ldr_wait = 0;
            cpu_hs = 0;
            ldr_hs = 0;
        end else begin
            exp_l = bus.ldr_valid && (!bus.cpu_valid || ldr_wait == STARVE_LIMIT);
            exp_c = bus.cpu_valid && !exp_l;
            chk("cpu_ready", 32'(bus.cpu_ready), 32'(exp_c));
            chk("ldr_ready", 32'(bus.ldr_ready), 32'(exp_l));
            ldr_wait = (bus.ldr_valid && exp_c) ? ldr_wait + 1 : 0;
            check_port(0, bus.cpu_ack, bus.cpu_rdata);
            check_port(1, bus.ldr_ack, bus.ldr_rdata);
            if (!bus.cpu_ack && !bus.ldr_ack) chk("err without ack", 32'(bus.err), 32'(0));
            cpu_hs = bus.cpu_valid && bus.cpu_ready;
            ldr_hs = bus.ldr_valid && bus.ldr_ready;
            if (cpu_hs) accept(0, bus.cpu_we, bus.cpu_addr, bus.cpu_wdata);
            if (ldr_hs) accept(1, bus.ldr_we, bus.ldr_addr, bus.ldr_wdata);
        end
    end
    initial begin : cpu_drv
        int idle;
        req_t r;
        idle = 0;
        bus.cpu_valid = 0;
        bus.cpu_we = 0;
        bus.cpu_addr = '0;
        bus.cpu_wdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (cpu_hs) bus.cpu_valid = 0;
            if (!bus.cpu_valid && req_q[0].size() != 0) begin
                if (idle >= req_q[0][0].gap) begin
                    r = req_q[0].pop_front();
                    idle = 0;
                    bus.cpu_valid = 1;
                    bus.cpu_we = r.we;
                    bus.cpu_addr = r.addr;
                    bus.cpu_wdata = r.wdata;
                end else idle++;
            end
        end
    end
    initial begin : ldr_drv
        int idle;
        req_t r;
        idle = 0;
        bus.ldr_valid = 0;
        bus.ldr_we = 0;
        bus.ldr_addr = '0;
        bus.ldr_wdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (ldr_hs) bus.ldr_valid = 0;
            if (!bus.ldr_valid && req_q[1].size() != 0) begin
                if (idle >= req_q[1][0].gap) begin
                    r = req_q[1].pop_front();
                    idle = 0;
                    bus.ldr_valid = 1;
                    bus.ldr_we = r.we;
                    bus.ldr_addr = r.addr;
                    bus.ldr_wdata = r.wdata;
                end else idle++;
            end
        end
    end
    task automatic push(input int p, input logic we, input int addr, input int wdata, input int gap);
        req_t r;
        r.we = we;
        r.addr = ADDR_W'(addr);
        r.wdata = DATA_W'(wdata);
        r.gap = gap;
        req_q[p].push_back(r);
    endtask
    task automatic drain();
        int n;
        n = 0;
        while ((req_q[0].size() != 0 || req_q[1].size() != 0 || bus.cpu_valid || bus.ldr_valid) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) begin
            vectors++;
            miscompares++;
            $display("FAIL drain timeout: requests still pending after %0d cycles", n);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask
    initial begin : main
        int n, sel, a;
        bus.wp_en = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            ram[i] = DATA_W'(i * 37 + 5);
            ref_mem[i] = DATA_W'(i * 37 + 5);
        end
        #1 reset_n = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        push(0, 1, 'h2100, 'h5A, 0);
        push(0, 0, 'h2100, 0, 0);
        drain();
        for (int i = 0; i < 12; i++) begin
            push(0, 0, 'h2000 + i, 0, 0);
            push(1, 0, 'h3000 + i, 0, 0);
        end
        drain();
        bus.wp_en = 1;
        push(0, 1, 'h0010, 'h11, 0);
        push(0, 0, 'h0010, 0, 0);
        drain();
        push(1, 1, 'h0010, 'h11, 0);
        drain();
        push(0, 0, 'h0010, 0, 0);
        drain();
        bus.wp_en = 0;
        push(1, 0, 'h3C00, 0, 0);
        push(0, 1, 'h3FFF, 'h77, 0);
        drain();
        for (int i = 0; i < 8; i++) begin
            push(1, 1, 'h1234, i * 17 + 3, i == 0 ? 0 : 1);
            push(0, 0, 'h1234, 0, 1);
        end
        drain();
        push(0, 0, 'h2100, 0, 0);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!cpu_hs && n < 50);
        if (!cpu_hs) begin
            vectors++;
            miscompares++;
            $display("FAIL reset accept timeout: cpu_ready not seen in %0d cycles", n);
        end
        @(posedge clk);
        #1 reset_n = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        push(0, 0, 'h2100, 0, 0);
        push(1, 1, 'h2100, 'hC3, 0);
        push(0, 0, 'h2100, 0, 1);
        drain();
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(3);
            a = sel == 0 ? int'($urandom_range(16383)) : sel == 1 ? 'h10 + int'($urandom_range(15))
              : sel == 2 ? 'h3BF0 + int'($urandom_range(31)) : 'h2100 + int'($urandom_range(7));
            if (i % 50 == 0) bus.wp_en = 1'($urandom_range(1));
            push(int'($urandom_range(1)), 1'($urandom_range(1)), a, int'($urandom_range(255)), int'($urandom_range(2)));
        end
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
